// File: rtl/io_bridge_fl_pkg.sv
// io_bridge_fl_pkg: shared word-size defaults and helpers for the FP core IO bridge
package io_bridge_fl_pkg;
  localparam int NBMANT_DEF = 16;
  localparam int NBEXPO_DEF = 6;
  localparam int NUIOIN_DEF = 8;
  localparam int NUIOOU_DEF = 8;
  localparam int OFDEPTH_DEF = 4;
  function automatic int word_w(input int nbmant, input int nbexpo);
    return nbmant + nbexpo + 1;
  endfunction
endpackage

// File: rtl/io_fifo.sv
// io_fifo: synchronous first-word-fall-through FIFO with count-based full/empty
module io_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  // pointers wrap naturally since depth is a power of two
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  // storage needs no reset; only slots below the count are ever visible
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  assign dout = mem[rp];
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
endmodule

// File: rtl/io_bridge_fl.sv
// io_bridge_fl: peripheral-side responder for the FP core IO port (input holding regs, output FIFO)
module io_bridge_fl
  import io_bridge_fl_pkg::*;
#(
  parameter int NBMANT = NBMANT_DEF,
  parameter int NBEXPO = NBEXPO_DEF,
  parameter int NUIOIN = NUIOIN_DEF,
  parameter int NUIOOU = NUIOOU_DEF,
  parameter int OFDEPTH = OFDEPTH_DEF,
  localparam int W = word_w(NBMANT, NBEXPO),
  localparam int AIW = $clog2(NUIOIN),
  localparam int AOW = $clog2(NUIOOU)
) (
  input  logic              clk,
  input  logic              rst,
  output logic [W-1:0]      io_in,
  input  logic [AIW-1:0]    addr_in,
  input  logic              req_in,
  input  logic [W-1:0]      data_out,
  input  logic [AOW-1:0]    addr_out,
  input  logic              out_en,
  input  logic [W-1:0]      ext_in_data,
  input  logic [AIW-1:0]    ext_in_addr,
  input  logic              ext_in_valid,
  output logic              ext_in_ready,
  output logic [NUIOIN-1:0] in_fresh,
  output logic [W-1:0]      ext_out_data,
  output logic [AOW-1:0]    ext_out_addr,
  output logic              ext_out_valid,
  input  logic              ext_out_ready,
  output logic              ovf,
  input  logic              ovf_clr
);
  logic [W-1:0] hreg [NUIOIN];
  logic [NUIOIN-1:0] we, rd;
  logic push, pop, full, empty;
  // address decode; out-of-range addresses match nothing, so they read 0 and are never ready
  always_comb begin
    io_in = '0;
    ext_in_ready = 1'b0;
    we = '0;
    rd = '0;
    for (int i = 0; i < NUIOIN; i++) begin
      io_in = (addr_in == AIW'(i)) ? hreg[i] : io_in;
      ext_in_ready = (ext_in_addr == AIW'(i)) ? ~in_fresh[i] : ext_in_ready;
      rd[i] = req_in & (addr_in == AIW'(i));
    end
    for (int i = 0; i < NUIOIN; i++)
      we[i] = ext_in_valid & ext_in_ready & (ext_in_addr == AIW'(i));
  end
  // holding registers; a write in the same cycle as a read leaves the value fresh
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int i = 0; i < NUIOIN; i++) hreg[i] <= '0;
      in_fresh <= '0;
    end else begin
      for (int i = 0; i < NUIOIN; i++) if (we[i]) hreg[i] <= ext_in_data;
      in_fresh <= we | (in_fresh & ~rd);
    end
  assign pop = ext_out_valid & ext_out_ready;
  assign push = out_en & (~full | pop);
  assign ext_out_valid = ~empty;
  io_fifo #(.WIDTH(AOW + W), .DEPTH(OFDEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   ({addr_out, data_out}),
    .dout  ({ext_out_addr, ext_out_data}),
    .full  (full),
    .empty (empty)
  );
  // sticky overflow on a dropped write; a new overflow beats a clear
  always_ff @(posedge clk or negedge rst)
    if (!rst) ovf <= 1'b0;
    else ovf <= (out_en & full & ~pop) | (ovf & ~ovf_clr);
endmodule

// File: tb/tb_io_bridge_fl.sv
// tb_io_bridge_fl: directed self-checking bench for io_bridge_fl
module tb_io_bridge_fl;
  logic clk = 0, rst = 0;
  logic [22:0] io_in, data_out, ext_in_data, ext_out_data;
  logic [2:0] addr_in, addr_out, ext_in_addr, ext_out_addr;
  logic req_in = 0, out_en = 0, ext_in_valid = 0, ext_out_ready = 0, ovf_clr = 0;
  logic ext_in_ready, ext_out_valid, ovf;
  logic [5:0] in_fresh;
  int tests = 0, fails = 0;

  io_bridge_fl #(.NUIOIN(6)) dut (
    .clk(clk), .rst(rst), .io_in(io_in), .addr_in(addr_in), .req_in(req_in),
    .data_out(data_out), .addr_out(addr_out), .out_en(out_en),
    .ext_in_data(ext_in_data), .ext_in_addr(ext_in_addr), .ext_in_valid(ext_in_valid),
    .ext_in_ready(ext_in_ready), .in_fresh(in_fresh), .ext_out_data(ext_out_data),
    .ext_out_addr(ext_out_addr), .ext_out_valid(ext_out_valid), .ext_out_ready(ext_out_ready),
    .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    ext_in_addr = 1; ext_in_data = 23'h55; ext_in_valid = 1;
    addr_out = 2; data_out = 23'h66; out_en = 1;
    tick;
    ext_in_valid = 0; out_en = 0; addr_in = 1;
    #1;
    tests++;
    if (io_in !== 23'h55 || ext_out_valid !== 1'b1) begin
      fails++; $display("FAIL preload: io_in=%h valid=%b want 55/1", io_in, ext_out_valid);
    end
    #2 rst = 0;
    #1;
    tests++;
    if (ext_out_valid !== 1'b0 || in_fresh !== 6'd0 || ovf !== 1'b0) begin
      fails++; $display("FAIL reset_state: valid=%b fresh=%b ovf=%b want 0/0/0", ext_out_valid, in_fresh, ovf);
    end
    for (int a = 0; a < 8; a++) begin
      addr_in = 3'(a);
      #1;
      tests++;
      if (io_in !== 23'd0) begin
        fails++; $display("FAIL reset_io_in[%0d]: got %h want 0", a, io_in);
      end
    end
    rst = 1;
    tick;
  endtask

  task automatic test_input_handshake;
    ext_in_addr = 3; ext_in_data = 23'h12345; ext_in_valid = 1;
    #1;
    tests++;
    if (ext_in_ready !== 1'b1) begin
      fails++; $display("FAIL hs_ready_initial: got %b want 1", ext_in_ready);
    end
    tick;
    ext_in_data = 23'h54321;
    #1;
    tests++;
    if (in_fresh[3] !== 1'b1 || ext_in_ready !== 1'b0) begin
      fails++; $display("FAIL hs_after_write: fresh3=%b ready=%b want 1/0", in_fresh[3], ext_in_ready);
    end
    tick;
    addr_in = 3;
    #1;
    tests++;
    if (io_in !== 23'h12345 || ext_in_ready !== 1'b0) begin
      fails++; $display("FAIL hs_stall: io_in=%h ready=%b want 12345/0", io_in, ext_in_ready);
    end
    req_in = 1;
    #1;
    tests++;
    if (io_in !== 23'h12345) begin
      fails++; $display("FAIL hs_read: io_in=%h want 12345", io_in);
    end
    tick;
    req_in = 0;
    #1;
    tests++;
    if (in_fresh[3] !== 1'b0 || ext_in_ready !== 1'b1 || io_in !== 23'h12345) begin
      fails++; $display("FAIL hs_cleared: fresh3=%b ready=%b io_in=%h want 0/1/12345", in_fresh[3], ext_in_ready, io_in);
    end
    tick;
    ext_in_valid = 0;
    #1;
    tests++;
    if (in_fresh[3] !== 1'b1 || io_in !== 23'h54321) begin
      fails++; $display("FAIL hs_stalled_accept: fresh3=%b io_in=%h want 1/54321", in_fresh[3], io_in);
    end
    req_in = 1;
    tick;
    req_in = 0;
  endtask

  task automatic test_collision;
    ext_in_addr = 5; ext_in_data = 23'h7; ext_in_valid = 1;
    tick;
    ext_in_valid = 0; addr_in = 5; req_in = 1;
    tick;
    req_in = 0;
    #1;
    tests++;
    if (in_fresh[5] !== 1'b0 || io_in !== 23'h7) begin
      fails++; $display("FAIL col_setup: fresh5=%b io_in=%h want 0/7", in_fresh[5], io_in);
    end
    ext_in_data = 23'h9; ext_in_valid = 1; req_in = 1;
    #1;
    tests++;
    if (io_in !== 23'h7 || ext_in_ready !== 1'b1) begin
      fails++; $display("FAIL col_same_cycle: io_in=%h ready=%b want 7/1", io_in, ext_in_ready);
    end
    tick;
    ext_in_valid = 0; req_in = 0;
    #1;
    tests++;
    if (io_in !== 23'h9 || in_fresh[5] !== 1'b1) begin
      fails++; $display("FAIL col_result: io_in=%h fresh5=%b want 9/1", io_in, in_fresh[5]);
    end
    req_in = 1;
    tick;
    req_in = 0;
  endtask

  task automatic test_fifo_order;
    logic [2:0] ea [3];
    logic [22:0] ed [3];
    ea[0] = 1; ea[1] = 2; ea[2] = 7;
    ed[0] = 23'hA; ed[1] = 23'hB; ed[2] = 23'hC;
    ext_out_ready = 0;
    addr_out = 1; data_out = 23'hA; out_en = 1;
    #1;
    tests++;
    if (ext_out_valid !== 1'b0) begin
      fails++; $display("FAIL fifo_empty_before: valid=%b want 0", ext_out_valid);
    end
    tick;
    tests++;
    if (ext_out_valid !== 1'b1 || ext_out_addr !== 3'd1 || ext_out_data !== 23'hA) begin
      fails++; $display("FAIL fifo_latency: valid=%b head=(%0d,%h) want 1 (1,a)", ext_out_valid, ext_out_addr, ext_out_data);
    end
    addr_out = 2; data_out = 23'hB;
    tick;
    addr_out = 7; data_out = 23'hC;
    tick;
    out_en = 0; ext_out_ready = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      tests++;
      if (ext_out_valid !== 1'b1 || ext_out_addr !== ea[k] || ext_out_data !== ed[k]) begin
        fails++; $display("FAIL fifo_order[%0d]: valid=%b head=(%0d,%h) want 1 (%0d,%h)", k, ext_out_valid, ext_out_addr, ext_out_data, ea[k], ed[k]);
      end
      tick;
    end
    tests++;
    if (ext_out_valid !== 1'b0) begin
      fails++; $display("FAIL fifo_drained: valid=%b want 0", ext_out_valid);
    end
    ext_out_ready = 0;
  endtask

  task automatic test_full_ovf;
    logic [22:0] ed [4];
    int n;
    ed[0] = 23'h101; ed[1] = 23'h102; ed[2] = 23'h103; ed[3] = 23'h1FF;
    ext_out_ready = 0; out_en = 1;
    for (int k = 0; k < 4; k++) begin
      addr_out = 3'(k); data_out = 23'h100 + 23'(k);
      tick;
    end
    tests++;
    if (ovf !== 1'b0) begin
      fails++; $display("FAIL full_no_ovf: ovf=%b want 0", ovf);
    end
    addr_out = 4; data_out = 23'h104;
    tick;
    tests++;
    if (ovf !== 1'b1) begin
      fails++; $display("FAIL ovf_set: ovf=%b want 1", ovf);
    end
    addr_out = 6; data_out = 23'h1FF; ext_out_ready = 1;
    tick;
    out_en = 0;
    #1;
    tests++;
    if (ovf !== 1'b1 || ext_out_data !== 23'h101) begin
      fails++; $display("FAIL push_pop_full: ovf=%b head=%h want 1/101", ovf, ext_out_data);
    end
    n = 0;
    for (int k = 0; k < 8 && ext_out_valid; k++) begin
      tests++;
      if (n > 3 || ext_out_data !== ed[n]) begin
        fails++; $display("FAIL drain[%0d]: got %h want %h", n, ext_out_data, (n > 3) ? 23'h0 : ed[n]);
      end
      n++;
      tick;
    end
    tests++;
    if (n !== 4) begin
      fails++; $display("FAIL drain_count: got %0d want 4", n);
    end
    ext_out_ready = 0; ovf_clr = 1;
    tick;
    ovf_clr = 0;
    tests++;
    if (ovf !== 1'b0) begin
      fails++; $display("FAIL ovf_clr: ovf=%b want 0", ovf);
    end
    out_en = 1;
    for (int k = 0; k < 5; k++) tick;
    ovf_clr = 1;
    tick;
    ovf_clr = 0; out_en = 0;
    tests++;
    if (ovf !== 1'b1) begin
      fails++; $display("FAIL ovf_set_wins: ovf=%b want 1", ovf);
    end
    ovf_clr = 1;
    tick;
    ovf_clr = 0;
    tests++;
    if (ovf !== 1'b0) begin
      fails++; $display("FAIL ovf_clr2: ovf=%b want 0", ovf);
    end
    ext_out_ready = 1;
    for (int k = 0; k < 4; k++) tick;
    ext_out_ready = 0;
  endtask

  task automatic test_out_of_range;
    ext_in_addr = 2; ext_in_data = 23'h4321; ext_in_valid = 1;
    tick;
    ext_in_valid = 0;
    for (int a = 6; a < 8; a++) begin
      addr_in = 3'(a); ext_in_addr = 3'(a); req_in = 1;
      #1;
      tests++;
      if (io_in !== 23'd0 || ext_in_ready !== 1'b0) begin
        fails++; $display("FAIL oor[%0d]: io_in=%h ready=%b want 0/0", a, io_in, ext_in_ready);
      end
      tick;
    end
    req_in = 0;
    tests++;
    if (in_fresh !== 6'b000100) begin
      fails++; $display("FAIL oor_no_effect: fresh=%b want 000100", in_fresh);
    end
  endtask

  initial begin
    addr_in = 0; addr_out = 0; data_out = 0; ext_in_addr = 0; ext_in_data = 0;
    #12 rst = 1;
    tick;
    test_reset;
    test_input_handshake;
    test_collision;
    test_fifo_order;
    test_full_ovf;
    test_out_of_range;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
